// File: rtl/clkscale_ctrl_pkg.sv
// rtl/clkscale_ctrl_pkg.sv - shared state encoding and one-hot helper for the clock scaler front panel
package clkscale_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_GAP    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    localparam int MAX_RATES = 32;

    // Callers size-cast the result down to their own rate count.
    function automatic logic [MAX_RATES-1:0] onehot(input logic [31:0] idx);
        logic [MAX_RATES-1:0] v;
        v = '0;
        if (idx < 32'(MAX_RATES)) begin
            v[idx[4:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/clkscale_ctrl_btn.sv
// rtl/clkscale_ctrl_btn.sv - per-button synchroniser, tick-based debounce, press and auto-repeat step pulses
module btn_debounce #(
    parameter int DEB_TICKS    = 4,
    parameter int REPEAT_TICKS = 8,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic press,
    output logic step
);

    localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    logic          sync_0;
    logic          sync_1;
    logic          stable;
    logic          stable_q;
    logic          rep_pulse;
    logic [DW-1:0] deb_cnt;
    logic [RW-1:0] rep_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_0    <= 1'b0;
            sync_1    <= 1'b0;
            stable    <= 1'b0;
            stable_q  <= 1'b0;
            rep_pulse <= 1'b0;
            deb_cnt   <= '0;
            rep_cnt   <= '0;
        end else begin
            sync_0    <= raw;
            sync_1    <= sync_0;
            stable_q  <= stable;
            rep_pulse <= 1'b0;

            // The level must disagree with stable on DEB_TICKS consecutive ticks to be accepted.
            if (tick) begin
                if (sync_1 == stable) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DW'(DEB_TICKS - 1)) begin
                    stable  <= sync_1;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end

            if (!stable || !REPEAT_EN) begin
                rep_cnt <= '0;
            end else if (tick) begin
                if (rep_cnt == RW'(REPEAT_TICKS - 1)) begin
                    rep_cnt   <= '0;
                    rep_pulse <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

    assign press = stable & ~stable_q;
    assign step  = press | rep_pulse;

endmodule

// File: rtl/clkscale_ctrl.sv
// rtl/clkscale_ctrl.sv - front-panel rate controller driving the scaler trigger with break-before-make
module clkscale_ctrl
    import clkscale_ctrl_pkg::*;
#(
    parameter int NUM_RATES    = 6,
    parameter int IDX_W        = 3,
    parameter int RST_RATE     = 2,
    parameter int DEB_TICKS    = 4,
    parameter int REPEAT_TICKS = 8,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ref_clk,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_pause,
    output logic [NUM_RATES-1:0] trigger,
    output logic [IDX_W-1:0]     rate_idx,
    output logic                 paused
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic                 ref_clk_q;
    logic                 tick;
    logic                 up_step;
    logic                 up_press;
    logic                 down_step;
    logic                 down_press;
    logic                 pause_press;
    logic                 pause_step;
    logic                 unused_events;
    logic [IDX_W-1:0]     next_idx;
    logic                 idx_change;
    logic [NUM_RATES-1:0] rate_oh;
    logic [GW-1:0]        gap_cnt;
    state_e               state;

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_clk_q <= 1'b0;
        end else begin
            ref_clk_q <= ref_clk;
        end
    end

    assign tick = ref_clk & ~ref_clk_q;

    btn_debounce #(
        .DEB_TICKS    (DEB_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS),
        .REPEAT_EN    (1'b1)
    ) u_btn_up (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (btn_up),
        .press (up_press),
        .step  (up_step)
    );

    btn_debounce #(
        .DEB_TICKS    (DEB_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS),
        .REPEAT_EN    (1'b1)
    ) u_btn_down (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (btn_down),
        .press (down_press),
        .step  (down_step)
    );

    btn_debounce #(
        .DEB_TICKS    (DEB_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS),
        .REPEAT_EN    (1'b0)
    ) u_btn_pause (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (btn_pause),
        .press (pause_press),
        .step  (pause_step)
    );

    // Raw presses of up/down are folded into their step pulses; pause only needs its press.
    assign unused_events = &{1'b0, up_press, down_press, pause_step};

    // Opposing steps in the same cycle cancel; saturation yields no change and therefore no gap.
    always_comb begin
        next_idx = rate_idx;
        if (up_step && !down_step && (rate_idx != IDX_W'(NUM_RATES - 1))) begin
            next_idx = rate_idx + 1'b1;
        end else if (down_step && !up_step && (rate_idx != '0)) begin
            next_idx = rate_idx - 1'b1;
        end
    end

    assign idx_change = (next_idx != rate_idx);
    assign rate_oh    = NUM_RATES'(onehot(32'(rate_idx)));

    always_ff @(posedge clk) begin
        if (reset) begin
            trigger  <= '0;
            rate_idx <= IDX_W'(RST_RATE);
            paused   <= 1'b0;
            state    <= ST_GAP;
            gap_cnt  <= GW'(GAP_CYCLES - 1);
        end else begin
            rate_idx <= next_idx;
            case (state)
                ST_RUN: begin
                    if (pause_press) begin
                        state   <= ST_PAUSED;
                        trigger <= '0;
                        paused  <= 1'b1;
                    end else if (idx_change) begin
                        state   <= ST_GAP;
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        trigger <= '0;
                    end else begin
                        trigger <= rate_oh;
                    end
                end
                ST_GAP: begin
                    trigger <= '0;
                    if (pause_press) begin
                        state  <= ST_PAUSED;
                        paused <= 1'b1;
                    end else if (idx_change) begin
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                    end else if (gap_cnt == '0) begin
                        // Index is known stable this cycle, so the new one-hot is safe to drive.
                        state   <= ST_RUN;
                        trigger <= rate_oh;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_PAUSED: begin
                    trigger <= '0;
                    paused  <= 1'b1;
                    if (pause_press) begin
                        state   <= ST_GAP;
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        paused  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_GAP;
                    gap_cnt <= GW'(GAP_CYCLES - 1);
                    trigger <= '0;
                    paused  <= 1'b0;
                end
            endcase
        end
    end

endmodule
